// File: rtl/poly_phase_accumulator.sv
// Time-multiplexed polyphonic phase accumulator: one sample tick scans every voice in
// ascending order and emits one registered (voice, phase, wrap) result per cycle.
module poly_phase_accumulator #(
  parameter int NUM_VOICES  = 8,
  parameter int PHASE_WIDTH = 32,
  parameter int INC_WIDTH   = 24,
  parameter int VW          = $clog2(NUM_VOICES)
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   sample_tick_in,
  input  logic [NUM_VOICES-1:0]  gate_in,
  input  logic                   inc_we_in,
  input  logic [VW-1:0]          inc_addr_in,
  input  logic [INC_WIDTH-1:0]   inc_data_in,
  output logic [PHASE_WIDTH-1:0] phase_out,
  output logic [VW-1:0]          voice_out,
  output logic                   valid_out,
  output logic                   last_out,
  output logic                   wrap_out,
  output logic                   busy_out,
  output logic                   overrun_out
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t                 state, state_nxt;
  logic [PHASE_WIDTH-1:0] phase [NUM_VOICES];
  logic [INC_WIDTH-1:0]   inc   [NUM_VOICES];
  logic [NUM_VOICES-1:0]  prev_gate, gate_snap;
  logic [VW-1:0]          idx;
  logic                   is_last;
  logic [PHASE_WIDTH:0]   acc_sum;
  logic [PHASE_WIDTH-1:0] upd_phase;
  logic                   upd_wrap;

  assign is_last = (idx == VW'(NUM_VOICES - 1));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: each always_comb assigns defaults first, so no path can leave a latch behind.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (sample_tick_in) state_nxt = SCAN;
      SCAN: if (is_last)        state_nxt = IDLE;
    endcase
  end

  // Update for the voice under the scan pointer; a new or released note restarts at zero.
  always_comb begin
    busy_out  = (state == SCAN);
    acc_sum   = {1'b0, phase[idx]} + {{(PHASE_WIDTH + 1 - INC_WIDTH){1'b0}}, inc[idx]};
    upd_phase = '0;
    upd_wrap  = 1'b0;
    if (gate_snap[idx] && prev_gate[idx]) begin
      upd_phase = acc_sum[PHASE_WIDTH-1:0];
      upd_wrap  = acc_sum[PHASE_WIDTH];
    end
  end

  // NOTE: the voice tables are plain flop arrays, so they can and must be cleared by reset;
  // a voice's first scan after reset then reads a zero increment.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        phase[v] <= '0;
        inc[v]   <= '0;
      end
      prev_gate   <= '0;
      gate_snap   <= '0;
      idx         <= '0;
      phase_out   <= '0;
      voice_out   <= '0;
      valid_out   <= 1'b0;
      last_out    <= 1'b0;
      wrap_out    <= 1'b0;
      overrun_out <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      last_out  <= 1'b0;
      wrap_out  <= 1'b0;

      // Same-edge write to the active voice lands after its read, so it counts from the next tick.
      if (inc_we_in && (int'(inc_addr_in) < NUM_VOICES))
        inc[inc_addr_in] <= inc_data_in;

      case (state)
        IDLE: begin
          if (sample_tick_in) begin
            gate_snap <= gate_in;
            idx       <= '0;
          end
        end
        SCAN: begin
          if (sample_tick_in) overrun_out <= 1'b1;
          phase[idx]     <= upd_phase;
          prev_gate[idx] <= gate_snap[idx];
          phase_out      <= upd_phase;
          voice_out      <= idx;
          valid_out      <= 1'b1;
          last_out       <= is_last;
          wrap_out       <= upd_wrap;
          if (!is_last) idx <= idx + VW'(1);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_poly_phase_accumulator.sv
// Directed bench for poly_phase_accumulator: 8 voices at 32/24 bits plus a 16/16-bit
// instance for carry-out, checked against hand-computed phases and cycle offsets.
module tb_poly_phase_accumulator;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        sample_tick_in;
  logic [7:0]  gate_in;
  logic        inc_we_in;
  logic [2:0]  inc_addr_in;
  logic [23:0] inc_data_in;
  logic [31:0] phase_out;
  logic [2:0]  voice_out;
  logic        valid_out, last_out, wrap_out, busy_out, overrun_out;

  logic [7:0]  gate16;
  logic        we16;
  logic [2:0]  addr16;
  logic [15:0] data16;
  logic [15:0] phase16;
  logic [2:0]  voice16;
  logic        valid16, last16, wrap16, busy16, ovr16;

  always #5 clk_in = ~clk_in;

  poly_phase_accumulator u_dut (
    .clk_in(clk_in), .rst_in(rst_in), .sample_tick_in(sample_tick_in), .gate_in(gate_in),
    .inc_we_in(inc_we_in), .inc_addr_in(inc_addr_in), .inc_data_in(inc_data_in),
    .phase_out(phase_out), .voice_out(voice_out), .valid_out(valid_out), .last_out(last_out),
    .wrap_out(wrap_out), .busy_out(busy_out), .overrun_out(overrun_out)
  );

  poly_phase_accumulator #(.NUM_VOICES(8), .PHASE_WIDTH(16), .INC_WIDTH(16)) u_dut16 (
    .clk_in(clk_in), .rst_in(rst_in), .sample_tick_in(sample_tick_in), .gate_in(gate16),
    .inc_we_in(we16), .inc_addr_in(addr16), .inc_data_in(data16),
    .phase_out(phase16), .voice_out(voice16), .valid_out(valid16), .last_out(last16),
    .wrap_out(wrap16), .busy_out(busy16), .overrun_out(ovr16)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] ph_seen   [8];
  logic        wr_seen   [8];
  logic [15:0] ph16_seen [8];
  logic        wr16_seen [8];
  logic        valid_h [32];
  logic        busy_h  [32];
  logic        ovr_h   [32];
  int          n_valid, n_busy, n_last, last_off, n_v0;
  int          v0_off [2];
  logic        order_ok;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic write_inc(input logic [2:0] addr, input logic [23:0] data);
    inc_we_in   = 1'b1;
    inc_addr_in = addr;
    inc_data_in = data;
    step();
    inc_we_in   = 1'b0;
  endtask

  // Tick in cycle c (now), then observe cycles c+1..c+n_cyc. Extra ticks come from
  // tick_mask[i]; an increment write and a reset pulse can be placed at chosen offsets.
  task automatic run_scan(input int n_cyc, input logic [31:0] tick_mask, input int wr_off,
                          input logic [2:0] wr_addr, input logic [23:0] wr_data, input int rst_off);
    for (int v = 0; v < 8; v++) begin
      ph_seen[v] = '1; wr_seen[v] = 1'bx; ph16_seen[v] = '1; wr16_seen[v] = 1'bx;
    end
    n_valid = 0; n_busy = 0; n_last = 0; last_off = -1; n_v0 = 0; order_ok = 1'b1;
    v0_off[0] = -1; v0_off[1] = -1;
    sample_tick_in = 1'b1;
    step();
    for (int i = 1; i <= n_cyc; i++) begin
      sample_tick_in = tick_mask[i];
      inc_we_in      = (i == wr_off);
      inc_addr_in    = wr_addr;
      inc_data_in    = wr_data;
      rst_in         = (i == rst_off);
      valid_h[i] = valid_out;
      busy_h[i]  = busy_out;
      ovr_h[i]   = overrun_out;
      if (busy_out) n_busy++;
      if (valid_out) begin
        if (int'(voice_out) != (n_valid % 8)) order_ok = 1'b0;
        if (last_out != (voice_out == 3'd7)) order_ok = 1'b0;
        ph_seen[voice_out] = phase_out;
        wr_seen[voice_out] = wrap_out;
        if (voice_out == 3'd0 && n_v0 < 2) begin
          v0_off[n_v0] = i;
          n_v0++;
        end
        n_valid++;
      end
      if (last_out) begin
        n_last++;
        last_off = i;
      end
      if (valid16) begin
        ph16_seen[voice16] = phase16;
        wr16_seen[voice16] = wrap16;
      end
      step();
    end
    sample_tick_in = 1'b0;
    inc_we_in      = 1'b0;
    rst_in         = 1'b0;
  endtask

  logic [31:0] others;
  logic        any_after;
  logic [31:0] exp_seq [6];

  initial begin
    rst_in = 1'b1; sample_tick_in = 1'b0; gate_in = '0;
    inc_we_in = 1'b0; inc_addr_in = '0; inc_data_in = '0;
    gate16 = '0; we16 = 1'b0; addr16 = '0; data16 = '0;
    step(); step();
    rst_in = 1'b0;
    step();

    check("rst valid",   valid_out,   1'b0);
    check("rst busy",    busy_out,    1'b0);
    check("rst overrun", overrun_out, 1'b0);
    check("rst phase",   phase_out,   32'd0);
    check("rst voice",   voice_out,   3'd0);
    check("rst last",    last_out,    1'b0);
    check("rst wrap",    wrap_out,    1'b0);

    // Basic accumulate on voice 0, wrap on the 16-bit instance's voice 1, same ticks.
    write_inc(3'd0, 24'd11237);
    we16 = 1'b1; addr16 = 3'd1; data16 = 16'h8000;
    step();
    we16 = 1'b0;
    gate_in = 8'h01;
    gate16  = 8'h02;
    for (int k = 0; k < 4; k++) begin
      run_scan(10, 32'h0, 0, 3'd0, 24'd0, 0);
      others = '0;
      for (int v = 1; v < 8; v++) others |= ph_seen[v];
      check($sformatf("acc v0 scan%0d", k), ph_seen[0], 32'(11237 * k));
      check($sformatf("acc others scan%0d", k), others, 32'd0);
      check($sformatf("acc nvalid scan%0d", k), n_valid, 8);
      check($sformatf("acc order scan%0d", k), order_ok, 1'b1);
      check($sformatf("acc v0 offset scan%0d", k), v0_off[0], 2);
      check($sformatf("acc last offset scan%0d", k), last_off, 9);
      check($sformatf("acc busy cycles scan%0d", k), n_busy, 8);
      check($sformatf("wrap16 phase scan%0d", k), ph16_seen[1], (k % 2 == 1) ? 16'h8000 : 16'h0000);
      check($sformatf("wrap16 flag scan%0d", k), wr16_seen[1], (k == 2));
    end
    check("hold voice after scan", voice_out, 3'd7);
    check("hold valid low", valid_out, 1'b0);
    gate16 = '0;

    // Overrun: ticks at c, c+3 (overrun) and c+9 (accepted, back-to-back).
    run_scan(20, (32'h1 << 3) | (32'h1 << 9), 0, 3'd0, 24'd0, 0);
    check("ovr nvalid",       n_valid,   16);
    check("ovr before",       ovr_h[3],  1'b0);
    check("ovr after",        ovr_h[4],  1'b1);
    check("ovr sticky",       overrun_out, 1'b1);
    check("ovr idle gap",     busy_h[9], 1'b0);
    check("ovr rescan busy",  busy_h[10], 1'b1);
    check("ovr v0 second",    v0_off[1], 11);
    check("ovr order",        order_ok,  1'b1);
    check("ovr v0 phase",     ph_seen[0], 32'd56185);

    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    step();
    check("ovr cleared by rst", overrun_out, 1'b0);

    // Gate retrigger on voice 2.
    write_inc(3'd2, 24'd1000);
    exp_seq[0] = 32'd0; exp_seq[1] = 32'd1000; exp_seq[2] = 32'd2000;
    exp_seq[3] = 32'd0; exp_seq[4] = 32'd0;    exp_seq[5] = 32'd1000;
    for (int k = 0; k < 6; k++) begin
      gate_in = (k == 3) ? 8'h00 : 8'h04;
      run_scan(10, 32'h0, 0, 3'd0, 24'd0, 0);
      check($sformatf("retrig v2 scan%0d", k), ph_seen[2], exp_seq[k]);
      check($sformatf("retrig wrap scan%0d", k), wr_seen[2], 1'b0);
    end

    // Write collision on voice 3: same-cycle write is deferred, earlier write is used.
    write_inc(3'd3, 24'd100);
    gate_in = 8'h08;
    run_scan(10, 32'h0, 0, 3'd0, 24'd0, 0);
    check("coll scan0", ph_seen[3], 32'd0);
    run_scan(10, 32'h0, 0, 3'd0, 24'd0, 0);
    check("coll scan1", ph_seen[3], 32'd100);
    run_scan(10, 32'h0, 4, 3'd3, 24'd500, 0);
    check("coll same-cycle write", ph_seen[3], 32'd200);
    run_scan(10, 32'h0, 0, 3'd0, 24'd0, 0);
    check("coll next tick", ph_seen[3], 32'd700);
    run_scan(10, 32'h0, 2, 3'd3, 24'd50, 0);
    check("coll early write", ph_seen[3], 32'd750);

    // Reset in cycle c+4 aborts the scan and clears the tables.
    gate_in = 8'hFF;
    run_scan(10, 32'h0, 0, 3'd0, 24'd0, 4);
    any_after = 1'b0;
    for (int i = 5; i <= 10; i++) any_after |= valid_h[i];
    check("rstmid nvalid",    n_valid,   3);
    check("rstmid no valid",  any_after, 1'b0);
    check("rstmid busy low",  busy_h[5], 1'b0);
    for (int k = 0; k < 2; k++) begin
      run_scan(10, 32'h0, 0, 3'd0, 24'd0, 0);
      others = '0;
      for (int v = 0; v < 8; v++) others |= ph_seen[v];
      check($sformatf("post-rst phases scan%0d", k), others, 32'd0);
      check($sformatf("post-rst nvalid scan%0d", k), n_valid, 8);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/poly_phase_accumulator.md
# poly_phase_accumulator

Time-multiplexed, parametrised phase accumulator for the polyphonic synth voice path. Once per audio sample tick it scans all voices in turn. Each voice gets a runtime-programmable tuning word and gate retrigger, and the block emits one (voice, phase, wrap) result per cycle. It sits between the key/gate decoder and the waveform lookup (sine ROM / sample BRAM readers), replacing fixed per-note increments with a writable increment table.

## Interface
Parameters:
- NUM_VOICES, 8, number of voices scanned per tick (≥2)
- PHASE_WIDTH, 32, accumulator width
- INC_WIDTH, 24, tuning-word width; must satisfy INC_WIDTH ≤ PHASE_WIDTH
- VW, $clog2(NUM_VOICES), derived voice-index width

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous, active-high reset
- sample_tick_in  input  1  one-cycle pulse at sample rate; starts a scan
- gate_in  input  NUM_VOICES  per-voice note gate
- inc_we_in  input  1  tuning-word write strobe
- inc_addr_in  input  VW  voice to write
- inc_data_in  input  INC_WIDTH  tuning word (phase increment per sample)
- phase_out  output  PHASE_WIDTH  updated phase of voice_out
- voice_out  output  VW  voice index of current result
- valid_out  output  1  result valid this cycle
- last_out  output  1  valid result is voice NUM_VOICES-1
- wrap_out  output  1  phase carried out of PHASE_WIDTH on this update
- busy_out  output  1  scan in progress
- overrun_out  output  1  sticky: tick arrived while busy

## Operation
- State: phase[NUM_VOICES], inc[NUM_VOICES], prev_gate[NUM_VOICES], gate_snap, idx, FSM {IDLE, SCAN}.
- IDLE with sample_tick_in=1:
  - gate_snap ← gate_in, idx ← 0, go to SCAN.
  - Gate changes during a scan are ignored until the next tick.
- SCAN, each cycle, voice v=idx:
  - gate_snap[v]=1, prev_gate[v]=0 (note-on): phase[v] ← 0, wrap 0.
  - gate_snap[v]=1, prev_gate[v]=1 (held): {carry, phase[v]} ← phase[v] + zero-extended inc[v]; wrap = carry.
  - gate_snap[v]=0: phase[v] ← 0, wrap 0.
  - prev_gate[v] ← gate_snap[v]. Registered outputs get the new phase, v, wrap, valid=1, last=(v==NUM_VOICES-1).
  - If v==NUM_VOICES-1, go to IDLE; else idx+1.
- Arithmetic is modulo 2^PHASE_WIDTH (wrap-around is intended, not saturated).
- Increment writes:
  - inc[inc_addr_in] ← inc_data_in at the edge. Accepted in any state.
  - Out-of-range address (≥NUM_VOICES) is ignored.
  - A write to the voice being processed in the same cycle does not affect that update (old value used); it applies from the next tick.
  - A write to a voice not yet reached in the current scan is used in that scan.
- Tick while FSM=SCAN: ignored; overrun_out ← 1 (sticky, cleared only by reset).
- Reset: state IDLE, idx 0, all phase/inc/prev_gate/gate_snap 0, all outputs 0 including overrun_out. Reset mid-scan aborts; no further valid_out.

## Timing
- Tick high in cycle c:
  - SCAN from cycle c+1 to c+NUM_VOICES; busy_out = (state==SCAN) in those cycles.
  - Voice k result valid in cycle c+2+k; last_out in cycle c+1+NUM_VOICES.
- Exactly NUM_VOICES consecutive valid_out pulses per accepted tick, voices in ascending order.
- Ticks in cycles c+1..c+NUM_VOICES are overruns. Next tick is accepted from cycle c+NUM_VOICES+1, overlapping the final valid result; back-to-back scans are permitted.
- Minimum tick period: NUM_VOICES+1 cycles.
- valid_out, last_out and wrap_out are single-cycle; phase_out/voice_out hold their last value when valid_out=0.
- Overrun flag visible from the cycle after the offending tick.

## Test plan
- Basic accumulate: reset, write inc[0]=11237, gate_in=0x01, three ticks. Voice 0 outputs 0, 11237, 22474; voices 1–7 output 0 every scan; 8 valid pulses per tick, last_out on voice 7.
- Wrap: PHASE_WIDTH=16, INC_WIDTH=16, inc[1]=0x8000, gate 0x02, four ticks. Voice 1 outputs 0, 0x8000, 0x0000 with wrap_out=1, then 0x8000 with wrap_out=0.
- Overrun: NUM_VOICES=8, tick at c and c+3. Only 8 valid pulses; overrun_out=1 from c+4 and stays 1. A tick at c+9 is accepted (valid for voice 0 at c+11).
- Gate retrigger: inc[2]=1000, gate[2] held 3 ticks (outputs 0, 1000, 2000), then low for one tick (0), then high again (0, then 1000).
- Write collision: inc[3]=100, held. inc_we_in to voice 3 with 500 in the cycle voice 3 is processed: this scan adds 100, the next adds 500. The same write landing before voice 3 is reached in the scan adds 500 in that scan.
- Reset mid-scan: assert rst_in in cycle c+4. valid_out=0 and busy_out=0 from c+5; a subsequent tick yields phase 0 for all voices with inc reads of 0.
